// File: rtl/linalg_pkg.sv
// Shared linalg definitions: element width, transpose FSM states,
// and the index-width helper used by the 2-D counters.
package linalg_pkg;

    localparam int LINALG_W = 32;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } xpose_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mat_transpose_stream_if.sv
// Element-serial stream bundle for mat_transpose_stream:
// producer side (in_*) and consumer side (out_*).
interface mat_transpose_stream_if
    import linalg_pkg::*;
#(
    parameter int W = LINALG_W
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last
    );

endinterface

// File: rtl/mat_idx_counter.sv
// 2-D wrap counter over a ROWS x COLS grid, stepping
// row-major (c fastest) or column-major (r fastest).
module mat_idx_counter
    import linalg_pkg::*;
#(
    parameter int ROWS      = 2,
    parameter int COLS      = 3,
    parameter bit COL_MAJOR = 1'b0,
    localparam int RW       = idx_w(ROWS),
    localparam int CW       = idx_w(COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [RW-1:0] r,
    output logic [CW-1:0] c,
    output logic          at_end
);

    logic r_end;
    logic c_end;

    assign r_end  = (r == RW'(ROWS - 1));
    assign c_end  = (c == CW'(COLS - 1));
    assign at_end = r_end && c_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
            c <= '0;
        end else if (clr) begin
            r <= '0;
            c <= '0;
        end else if (inc) begin
            if (COL_MAJOR) begin
                if (r_end) begin
                    r <= '0;
                    c <= c_end ? '0 : c + 1'b1;
                end else begin
                    r <= r + 1'b1;
                end
            end else begin
                if (c_end) begin
                    c <= '0;
                    r <= r_end ? '0 : r + 1'b1;
                end else begin
                    c <= c + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mat_transpose_stream.sv
// Buffers an M x N matrix fed row-major, then streams its
// N x M transpose row-major (column-major walk of the input).
module mat_transpose_stream
    import linalg_pkg::*;
#(
    parameter int M = 2,
    parameter int N = 3,
    parameter int W = LINALG_W,
    localparam int RW = idx_w(M),
    localparam int CW = idx_w(N)
) (
    input logic                   clk,
    input logic                   rst_n,
    mat_transpose_stream_if.slave s
);

    xpose_state_t state_q;
    xpose_state_t state_d;

    logic [RW-1:0] fill_r;
    logic [CW-1:0] fill_c;
    logic [RW-1:0] drain_r;
    logic [CW-1:0] drain_c;
    logic          fill_end;
    logic          drain_end;
    logic          in_xfer;
    logic          out_xfer;

    logic [W-1:0] mem [M][N];

    assign s.in_ready  = (state_q == FILL);
    assign s.out_valid = (state_q == DRAIN);
    assign in_xfer     = s.in_valid && s.in_ready;
    assign out_xfer    = s.out_valid && s.out_ready;

    mat_idx_counter #(
        .ROWS      (M),
        .COLS      (N),
        .COL_MAJOR (1'b0)
    ) u_fill_idx (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_q != FILL),
        .inc    (in_xfer),
        .r      (fill_r),
        .c      (fill_c),
        .at_end (fill_end)
    );

    mat_idx_counter #(
        .ROWS      (M),
        .COLS      (N),
        .COL_MAJOR (1'b1)
    ) u_drain_idx (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_q != DRAIN),
        .inc    (out_xfer),
        .r      (drain_r),
        .c      (drain_c),
        .at_end (drain_end)
    );

    // Payload storage is never reset; only the FSM and counters are.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            mem[fill_r][fill_c] <= s.in_data;
        end
    end

    assign s.out_data = mem[drain_r][drain_c];
    assign s.out_last = s.out_valid && drain_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: begin
                if (in_xfer && fill_end) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_xfer && drain_end) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

endmodule

// File: tb/tb_mat_transpose_stream.sv
// Directed and randomized bench for mat_transpose_stream
// across 2x3, 3x1, 1x1 and 4x5 configurations.
module tb_mat_transpose_stream;
    import linalg_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mat_transpose_stream_if #(.W(32)) ia ();
    mat_transpose_stream_if #(.W(32)) ib ();
    mat_transpose_stream_if #(.W(32)) ic ();
    mat_transpose_stream_if #(.W(32)) id ();

    mat_transpose_stream #(.M(2), .N(3), .W(32)) dut_a (.clk(clk), .rst_n(rst_n), .s(ia));
    mat_transpose_stream #(.M(3), .N(1), .W(32)) dut_b (.clk(clk), .rst_n(rst_n), .s(ib));
    mat_transpose_stream #(.M(1), .N(1), .W(32)) dut_c (.clk(clk), .rst_n(rst_n), .s(ic));
    mat_transpose_stream #(.M(4), .N(5), .W(32)) dut_d (.clk(clk), .rst_n(rst_n), .s(id));

    logic [31:0] mats [2][6] = '{
        '{32'h3F800000, 32'h40000000, 32'h40400000,
          32'h40800000, 32'h40A00000, 32'h40C00000},
        '{32'h40E00000, 32'h41000000, 32'h41100000,
          32'h41200000, 32'h41300000, 32'h41400000}};
    logic [31:0] exps [2][6] = '{
        '{32'h3F800000, 32'h40800000, 32'h40000000,
          32'h40A00000, 32'h40400000, 32'h40C00000},
        '{32'h40E00000, 32'h41200000, 32'h41000000,
          32'h41300000, 32'h41100000, 32'h41400000}};
    logic [31:0] deg3 [3] = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};

    logic [31:0] expq [$];

    task automatic idle_all;
        ia.in_valid = 0; ia.in_data = '0; ia.out_ready = 0;
        ib.in_valid = 0; ib.in_data = '0; ib.out_ready = 0;
        ic.in_valid = 0; ic.in_data = '0; ic.out_ready = 0;
        id.in_valid = 0; id.in_data = '0; id.out_ready = 0;
    endtask

    task automatic fill_a(input int m);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_chk++;
            if (ia.in_ready !== 1'b1 || ia.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_a[%0d] in_ready/out_valid: got %b/%b want 1/0",
                         i, ia.in_ready, ia.out_valid);
            end
            ia.in_valid = 1'b1;
            ia.in_data  = mats[m][i];
        end
    endtask

    task automatic drain_a(input int m, input bit stall, input bit hold);
        int k = 0;
        int p = 0;
        bit rdy;
        while (k < 6 && p < 40) begin
            @(negedge clk);
            ia.in_valid = hold;
            n_chk++;
            if (ia.out_valid !== 1'b1 || ia.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_a[%0d] out_valid/in_ready: got %b/%b want 1/0",
                         k, ia.out_valid, ia.in_ready);
            end
            n_chk++;
            if (ia.out_data !== exps[m][k]) begin
                n_fail++;
                $display("FAIL drain_a data[%0d]: got %h want %h", k, ia.out_data, exps[m][k]);
            end
            n_chk++;
            if (ia.out_last !== (k == 5)) begin
                n_fail++;
                $display("FAIL drain_a last[%0d]: got %b want %b", k, ia.out_last, k == 5);
            end
            rdy = stall ? ((p % 4 == 0) || (p % 4 == 3)) : 1'b1;
            p++;
            ia.out_ready = rdy;
            if (rdy) k++;
        end
        n_chk++;
        if (k != 6) begin
            n_fail++;
            $display("FAIL drain_a timeout: got %0d outputs want 6", k);
        end
    endtask

    task automatic check_idle_a;
        @(negedge clk);
        ia.out_ready = 1'b0;
        n_chk++;
        if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1 || ia.out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_a valid/ready/last: got %b/%b/%b want 0/1/0",
                     ia.out_valid, ia.in_ready, ia.out_last);
        end
    endtask

    task automatic test_reset;
        idle_all();
        #1 rst_n = 1'b0;
        #11;
        n_chk++;
        if ({ia.in_ready, ib.in_ready, ic.in_ready, id.in_ready} !== 4'hF) begin
            n_fail++;
            $display("FAIL reset in_ready: got %b want 1111",
                     {ia.in_ready, ib.in_ready, ic.in_ready, id.in_ready});
        end
        n_chk++;
        if ({ia.out_valid, ib.out_valid, ic.out_valid, id.out_valid,
             ia.out_last, id.out_last} !== 6'h0) begin
            n_fail++;
            $display("FAIL reset out_valid/out_last: got nonzero want 0");
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_no_stall;
        fill_a(0);
        drain_a(0, 1'b0, 1'b0);
        check_idle_a();
    endtask

    task automatic test_stall;
        fill_a(0);
        drain_a(0, 1'b1, 1'b0);
        check_idle_a();
    endtask

    task automatic test_back_to_back;
        fill_a(0);
        drain_a(0, 1'b0, 1'b1);
        fill_a(1);
        drain_a(1, 1'b0, 1'b0);
        check_idle_a();
    endtask

    task automatic test_reset_mid_drain;
        fill_a(0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ia.in_valid  = 1'b0;
            ia.out_ready = (k < 2);
            n_chk++;
            if (ia.out_data !== exps[0][k]) begin
                n_fail++;
                $display("FAIL mid_drain data[%0d]: got %h want %h", k, ia.out_data, exps[0][k]);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset valid/ready: got %b/%b want 0/1",
                     ia.out_valid, ia.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fill_a(1);
        drain_a(1, 1'b0, 1'b0);
        check_idle_a();
    endtask

    task automatic test_degenerate;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ib.in_valid = 1'b1;
            ib.in_data  = deg3[i];
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ib.in_valid  = 1'b0;
            ib.out_ready = 1'b1;
            n_chk++;
            if (ib.out_valid !== 1'b1 || ib.out_data !== deg3[k] || ib.out_last !== (k == 2)) begin
                n_fail++;
                $display("FAIL m3n1[%0d] valid/data/last: got %b/%h/%b want 1/%h/%b",
                         k, ib.out_valid, ib.out_data, ib.out_last, deg3[k], k == 2);
            end
        end
        @(negedge clk);
        ib.out_ready = 1'b0;
        ic.in_valid  = 1'b1;
        ic.in_data   = 32'h3F800000;
        n_chk++;
        if (ib.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL m3n1 done out_valid: got %b want 0", ib.out_valid);
        end
        @(negedge clk);
        ic.in_valid  = 1'b0;
        ic.out_ready = 1'b1;
        n_chk++;
        if (ic.out_valid !== 1'b1 || ic.out_data !== 32'h3F800000 || ic.out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL m1n1 valid/data/last: got %b/%h/%b want 1/3f800000/1",
                     ic.out_valid, ic.out_data, ic.out_last);
        end
        @(negedge clk);
        ic.out_ready = 1'b0;
        n_chk++;
        if (ic.out_valid !== 1'b0 || ic.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL m1n1 done valid/ready: got %b/%b want 0/1", ic.out_valid, ic.in_ready);
        end
    endtask

    task automatic test_random;
        expq.delete();
        fork
            begin : producer
                logic [31:0] mtx [4][5];
                int pc = 0;
                bit v;
                for (int m = 0; m < 200 && pc < 40000; m++) begin
                    for (int r = 0; r < 4; r++)
                        for (int c = 0; c < 5; c++)
                            mtx[r][c] = $urandom;
                    for (int c = 0; c < 5; c++)
                        for (int r = 0; r < 4; r++)
                            expq.push_back(mtx[r][c]);
                    for (int e = 0; e < 20 && pc < 40000;) begin
                        @(negedge clk);
                        pc++;
                        v = ($urandom_range(0, 3) != 0);
                        id.in_valid = v;
                        id.in_data  = mtx[e / 5][e % 5];
                        if (v && id.in_ready) e++;
                    end
                end
                @(negedge clk);
                id.in_valid = 1'b0;
                n_chk++;
                if (pc >= 40000) begin
                    n_fail++;
                    $display("FAIL random producer timeout: got %0d cycles want <40000", pc);
                end
            end
            begin : consumer
                int got = 0;
                int cc  = 0;
                bit rdy;
                logic [31:0] want;
                while (got < 4000 && cc < 40000) begin
                    @(negedge clk);
                    cc++;
                    n_chk++;
                    if (id.in_ready && id.out_valid) begin
                        n_fail++;
                        $display("FAIL random overlap: got in_ready=1 out_valid=1 want exclusive");
                    end
                    rdy = ($urandom_range(0, 3) != 0);
                    id.out_ready = rdy;
                    if (id.out_valid && rdy) begin
                        want = (expq.size() != 0) ? expq.pop_front() : 32'hDEADBEEF;
                        n_chk++;
                        if (id.out_data !== want || id.out_last !== (got % 20 == 19)) begin
                            n_fail++;
                            $display("FAIL random out[%0d] data/last: got %h/%b want %h/%b",
                                     got, id.out_data, id.out_last, want, got % 20 == 19);
                        end
                        got++;
                    end
                end
                @(negedge clk);
                id.out_ready = 1'b0;
                n_chk++;
                if (got != 4000) begin
                    n_fail++;
                    $display("FAIL random consumer timeout: got %0d outputs want 4000", got);
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_no_stall();
        test_stall();
        test_back_to_back();
        test_reset_mid_drain();
        test_degenerate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mat_transpose_stream.md
# mat_transpose_stream

Sequential, handshaked counterpart of the combinational `mat_transpose` in `v/linalg`. It accepts an M×N matrix of W-bit words (IEEE-754 single by default) one element per beat in row-major order. It stores the full matrix, then emits the N×M transpose one element per beat, also in row-major order of the result, which is column-major order of the input. It sits between element-serial producers (loaders, MAC arrays) and consumers that need transposed operands without a wide packed bus.

## Interface
Parameters:
- `M`, default 2: rows of the input matrix; must be ≥1.
- `N`, default 3: columns of the input matrix; must be ≥1.
- `W`, default 32: element width in bits. Elements are opaque words; no arithmetic is performed on them.

Ports:
- `clk`, input, 1: the only clock; all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous reset, active-low.
- `in_valid`, input, 1: an input element is presented.
- `in_ready`, output, 1: the block can accept an input element.
- `in_data`, input, W: input element, row-major.
- `out_valid`, output, 1: an output element is presented.
- `out_ready`, input, 1: the consumer accepts the output element.
- `out_data`, output, W: output element, transposed order.
- `out_last`, output, 1: high with the final element of a transposed matrix.

## Operation
- Storage: M·N register array `buf[r][c]`, plus counters `r` (0..M-1) and `c` (0..N-1). Counter widths are `$clog2` of the count, with a minimum of 1.
- There are two states.
  - FILL: `in_ready`=1 and `out_valid`=0. On each input transfer (`in_valid`&&`in_ready`), write `buf[r][c]` = `in_data`. Then advance `c`; when `c` wraps from N-1 to 0, advance `r`. On the transfer with r=M-1 and c=N-1, clear both counters and go to DRAIN.
  - DRAIN: `in_ready`=0 and `out_valid`=1. `out_data` = `buf[r][c]`, driven combinationally from the registered array and counters. On each output transfer (`out_valid`&&`out_ready`), advance `r`; when `r` wraps from M-1 to 0, advance `c`. `out_last`=1 when r=M-1 and c=N-1. On the `out_last` transfer, clear the counters and go to FILL.
- Input and output never transfer in the same cycle, so there is no simultaneous-event hazard by construction.
- `in_data` is ignored when no transfer occurs. `out_data` is don't-care when `out_valid`=0; the bench must not check it then.
- Backpressure:
  - `out_ready`=0 holds `out_data`, `out_valid` and `out_last` stable.
  - `in_valid`=0 in FILL stalls the fill with no state change.
- Degenerate sizes:
  - M=1 or N=1: output order equals input order; the block still buffers the whole matrix.
  - M=N=1: one in, one out, and `out_last` is high on that single beat.
- Reset applies at any time, including mid-FILL or mid-DRAIN. It aborts the current matrix with no partial output. Buffer contents need not be cleared.

## Timing
- Reset values: state=FILL, r=c=0, `in_ready`=1, `out_valid`=0, `out_last`=0. `out_data` is unspecified.
- `out_valid` rises in the cycle after the final input transfer.
- The first output element is available one cycle after the last input is accepted, giving a latency of M·N+1 cycles from the first input at full throughput.
- `in_ready` rises in the cycle after the `out_last` transfer.
- Throughput: 1 element/cycle per phase. One matrix takes 2·M·N cycles with no stalls; phases do not overlap.
- `in_ready` and `out_valid` depend only on registered state. Neither has a combinational path from `in_valid` or `out_ready`.

## Structure
- The shared package `linalg_pkg` holds the state enum `xpose_state_t` {FILL, DRAIN}.
- The package also holds the default element width constant `LINALG_W = 32`, so sibling linalg blocks share it.
- One sub-module is natural: `mat_idx_counter`, a 2-D wrap counter.
  - Parameters: the two limits and a row-major/column-major select.
  - Ports: `clk`, `rst_n`, `clr`, `inc`, `r`, `c`, `at_end`.
  - It is used once, with the mode switched by state. Two instances are also acceptable.
- The storage array and output mux live in `mat_transpose_stream` itself.

## Test plan
- M=2, N=3, no stalls: feed 3F800000, 40000000, 40400000, 40800000, 40A00000, 40C00000. Require output 3F800000, 40800000, 40000000, 40A00000, 40400000, 40C00000, with `out_last` only on the 6th output and `out_valid` rising exactly one cycle after the 6th input.
- Same data with `out_ready` toggled 1,0,0,1,…: output order is unchanged, `out_data`/`out_last` are held through stalls, and no element is dropped or duplicated.
- Two back-to-back matrices with `in_valid` held high:
  - `in_ready`=0 for all 6 DRAIN cycles.
  - The second matrix [7..12] (40E00000…41400000) emits 40E00000, 41200000, 41000000, 41300000, 41100000, 41400000.
- Reset mid-DRAIN after 2 outputs: pull `rst_n` low asynchronously between clock edges. `out_valid`=0 and `in_ready`=1 immediately. A fresh matrix then transposes correctly from index 0.
- M=3, N=1 with inputs A, B, C: the outputs are A, B, C. Then M=1, N=1 with input 3F800000: one output, `out_last`=1.
- Random `in_valid`/`out_ready`, M=4, N=5, 200 matrices: compare against a scoreboard transpose model, and check that `in_valid`&&`in_ready` and `out_valid`&&`out_ready` never overlap.
